// File: rtl/lsu_mem_master.sv
// Load/store initiator for the 64-bit combinational-read data memory.
// Define LSU_MISALIGN_EN to split line-crossing accesses into two beats; otherwise misaligned requests are rejected.
module lsu_mem_master #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [63:0]       wdata_q;
  logic              mis_q;
  logic [63:0]       asm_q;

  logic [2:0]        off_q;
  logic [3:0]        n_q;
  logic [7:0]        wmask0;
  logic [ADDR_W-1:0] base_addr;
  logic              req_mis;

  assign off_q     = addr_q[2:0];
  assign n_q       = 4'd1 << size_q;
  assign wmask0    = (8'hFF >> (4'd8 - n_q)) << off_q;
  assign base_addr = {addr_q[ADDR_W-1:3], 3'b000};

`ifdef LSU_MISALIGN_EN
  logic [3:0] span;
  logic       cross_q;
  logic [2:0] n2;
  logic [5:0] sh1;
  logic [7:0] wmask1;

  assign span    = {1'b0, off_q} + n_q;
  assign cross_q = span > 4'd8;
  assign n2      = span[2:0];
  // 8*(8-off) as a bit shift; only used when off != 0
  assign sh1     = {3'(3'd0 - off_q), 3'b000};
  assign wmask1  = (8'd1 << n2) - 8'd1;
  assign req_mis = 1'b0;
`else
  always_comb begin
    case (req_size)
      2'd0:    req_mis = 1'b0;
      2'd1:    req_mis = req_addr[0];
      2'd2:    req_mis = |req_addr[1:0];
      default: req_mis = |req_addr[2:0];
    endcase
  end
`endif

  function automatic logic [63:0] lane_bits(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                         input logic uns);
    logic [63:0] r;
    case (sz)
      2'd0:    r = {{56{v[7]  & ~uns}}, v[7:0]};
      2'd1:    r = {{48{v[15] & ~uns}}, v[15:0]};
      2'd2:    r = {{32{v[31] & ~uns}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = req_mis ? RESP : BEAT0;
`ifdef LSU_MISALIGN_EN
      BEAT0: state_nxt = cross_q ? BEAT1 : RESP;
`else
      BEAT0: state_nxt = RESP;
`endif
      BEAT1: state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields and load assembly register; data only, no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
      mis_q   <= req_mis;
      asm_q   <= '0;
    end else if (state == BEAT0 && !we_q) begin
      asm_q <= mem_rdata >> {off_q, 3'b000};
`ifdef LSU_MISALIGN_EN
    end else if (state == BEAT1 && !we_q) begin
      asm_q <= asm_q | ((mem_rdata & lane_bits(wmask1)) << sh1);
`endif
    end
  end

  always_comb begin
    req_ready     = (state == IDLE);
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_misalign = 1'b0;
    mem_ce        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    case (state)
      BEAT0: begin
        mem_ce    = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr;
        mem_wmask = wmask0;
        mem_wdata = wdata_q << {off_q, 3'b000};
      end
`ifdef LSU_MISALIGN_EN
      BEAT1: begin
        mem_ce    = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr + ADDR_W'(8);
        mem_wmask = wmask1;
        mem_wdata = wdata_q >> sh1;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = (we_q || mis_q) ? 64'd0 : extend(asm_q, size_q, uns_q);
`ifndef LSU_MISALIGN_EN
        resp_misalign = mis_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed vector table, hand sequences, and random traffic
// checked against a byte-array memory model.
module tb_lsu_mem_master;
  localparam int ADDR_W = 64;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [63:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [63:0]       resp_rdata;
  logic              resp_misalign;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wmask;
  logic [63:0]       mem_rdata;

  lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT: 16 dwords at BASE, combinational read
  logic [63:0] mem [16] = '{0: 64'h0000_0000_80FF_0000, 1: 64'h0000_0000_0000_F234,
                            default: 64'hA5C3_9612_7E48_F01D};
  assign mem_rdata = mem[mem_addr[6:3]];

  int          ce_cnt = 0;
  logic [63:0] bl_addr[$];
  logic [7:0]  bl_mask[$];
  logic [63:0] bl_wdata[$];
  logic        bl_we[$];

  always @(posedge clk) begin
    if (mem_ce) begin
      ce_cnt <= ce_cnt + 1;
      bl_addr.push_back(mem_addr);
      bl_mask.push_back(mem_wmask);
      bl_wdata.push_back(mem_wdata);
      bl_we.push_back(mem_we);
      if (mem_we)
        for (int b = 0; b < 8; b++)
          if (mem_wmask[b]) mem[mem_addr[6:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model: plain byte array
  logic [7:0] refb [128];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz,
                                           input logic uns);
    int n = 1 << sz;
    int o = int'(a - BASE);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = refb[o + i];
    if (!uns && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
    int n = 1 << sz;
    int o = int'(a - BASE);
    for (int i = 0; i < n; i++) refb[o + i] = d[8*i +: 8];
  endtask

  function automatic logic ref_mis(input logic [63:0] a, input logic [1:0] sz);
`ifdef LSU_MISALIGN_EN
    return 1'b0;
`else
    return (a % (64'd1 << sz)) != 0;
`endif
  endfunction

  // One transaction; lat = edges after the accept edge until resp_valid is seen
  task automatic run_req(input logic [63:0] a, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [63:0] wd, input int hold,
                         output logic [63:0] rd, output logic mis, output int lat,
                         output int beats, output int q0);
    int c0;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    q0 = bl_addr.size();
    c0 = ce_cnt;
    req_addr = a; req_we = we; req_size = sz; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      errors++; checks++;
      $display("FAIL resp_timeout: got no resp_valid after %0d cycles, required within 8", lat);
    end
    rd  = resp_rdata;
    mis = resp_misalign;
    if (hold > 0) begin
      req_addr = BASE + 64'h40; req_we = 1'b1; req_size = 2'd3; req_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("hold_resp_rdata", resp_rdata, rd);
        chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
      end
      req_valid = 1'b0;
    end
    beats = ce_cnt - c0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_taken", {62'd0, resp_valid, req_ready}, 64'd1);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    int          hold;
    logic [63:0] exp_rd;
    logic        exp_mis;
    int          exp_lat;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  initial begin
    logic [63:0] rd, erd, a;
    logic        mis, emis, we, uns, crossing, rv_seen;
    logic [1:0]  sz;
    logic [63:0] wd;
    int          lat, beats, q0, c0, elat;

    vec[0] = '{BASE + 3, 1'b0, 2'd0, 1'b0, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1};
    vec[1] = '{BASE + 3, 1'b0, 2'd0, 1'b1, 64'd0, 0, 64'h0000_0000_0000_0080, 1'b0, 1};
    vec[2] = '{BASE + 2, 1'b0, 2'd1, 1'b0, 64'd0, 0, 64'hFFFF_FFFF_FFFF_80FF, 1'b0, 1};
    vec[3] = '{BASE + 0, 1'b0, 2'd2, 1'b1, 64'd0, 0, 64'h0000_0000_80FF_0000, 1'b0, 1};
    vec[4] = '{BASE + 0, 1'b0, 2'd3, 1'b0, 64'd0, 0, 64'h0000_0000_80FF_0000, 1'b0, 1};
    vec[5] = '{BASE + 6, 1'b1, 2'd1, 1'b0, 64'h1111_2222_3333_ABCD, 0, 64'd0, 1'b0, 1};
    vec[6] = '{BASE + 6, 1'b0, 2'd1, 1'b0, 64'd0, 5, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0, 1};
`ifdef LSU_MISALIGN_EN
    vec[7] = '{BASE + 6, 1'b0, 2'd2, 1'b0, 64'd0, 0, 64'hFFFF_FFFF_F234_ABCD, 1'b0, 2};
    vec[8] = '{BASE + 7, 1'b0, 2'd1, 1'b1, 64'd0, 0, 64'h0000_0000_0000_34AB, 1'b0, 2};
`else
    vec[7] = '{BASE + 6, 1'b0, 2'd2, 1'b0, 64'd0, 0, 64'd0, 1'b1, 0};
    vec[8] = '{BASE + 7, 1'b0, 2'd1, 1'b1, 64'd0, 0, 64'd0, 1'b1, 0};
`endif

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp", {61'd0, resp_valid, resp_misalign, |resp_rdata}, 64'd0);
    chk("rst_mem_ctl", {54'd0, mem_ce, mem_we, mem_wmask}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);

    for (int i = 0; i < 128; i++) refb[i] = mem[i/8][8*(i%8) +: 8];

    for (int i = 0; i < NV; i++) begin
      run_req(vec[i].addr, vec[i].we, vec[i].size, vec[i].uns, vec[i].wdata, vec[i].hold,
              rd, mis, lat, beats, q0);
      chk($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rd);
      chk($sformatf("vec%0d_misalign", i), {63'd0, mis}, {63'd0, vec[i].exp_mis});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vec[i].exp_lat));
      chk($sformatf("vec%0d_beats", i), 64'(beats), 64'(vec[i].exp_lat));
      if (vec[i].we && !vec[i].exp_mis) ref_store(vec[i].addr, vec[i].size, vec[i].wdata);
      if (i == 0 && beats == 1) chk("loadb_beat_addr", bl_addr[q0], BASE);
      if (i == 5 && beats == 1) begin
        chk("storeh_addr", bl_addr[q0], BASE);
        chk("storeh_wmask", {56'd0, bl_mask[q0]}, 64'hC0);
        chk("storeh_wdata_hi", {48'd0, bl_wdata[q0][63:48]}, 64'hABCD);
        chk("storeh_we", {63'd0, bl_we[q0]}, 64'd1);
      end
`ifdef LSU_MISALIGN_EN
      if (i == 7 && beats == 2) begin
        chk("loadw_beat0_addr", bl_addr[q0], BASE);
        chk("loadw_beat1_addr", bl_addr[q0+1], BASE + 8);
        chk("loadw_beat0_mask", {56'd0, bl_mask[q0]}, 64'hC0);
        chk("loadw_beat1_mask", {56'd0, bl_mask[q0+1]}, 64'h03);
      end
`endif
    end

    for (int i = 0; i < 80; i++) begin
      a   = BASE + 64'($urandom_range(0, 119));
      sz  = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      emis = ref_mis(a, sz);
      crossing = (a[2:0] + (64'd1 << sz)) > 64'd8;
      elat = emis ? 0 : (crossing ? 2 : 1);
      erd  = (we || emis) ? 64'd0 : ref_load(a, sz, uns);
      run_req(a, we, sz, uns, wd, (i % 9 == 0) ? 2 : 0, rd, mis, lat, beats, q0);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk($sformatf("rnd%0d_misalign", i), {63'd0, mis}, {63'd0, emis});
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(elat));
      chk($sformatf("rnd%0d_beats", i), 64'(beats), 64'(elat));
      if (beats > 0) chk($sformatf("rnd%0d_beat_addr", i), bl_addr[q0], a & ~64'h7);
      if (we && !emis) ref_store(a, sz, wd);
    end

    for (int d = 0; d < 16; d++) begin
      logic [63:0] ed;
      for (int b = 0; b < 8; b++) ed[8*b +: 8] = refb[8*d + b];
      chk($sformatf("mem_dw%0d", d), mem[d], ed);
    end

    // Reset while a store is in flight (second beat when splitting is enabled)
`ifdef LSU_MISALIGN_EN
    req_addr = BASE + 64'h46;
`else
    req_addr = BASE + 64'h44;
`endif
    req_we = 1'b1; req_size = 2'd2; req_wdata = 64'h0000_0000_DEAD_BEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("inflight_beat0_ce", {63'd0, mem_ce}, 64'd1);
`ifdef LSU_MISALIGN_EN
    @(posedge clk); #1;
    chk("inflight_beat1_ce", {63'd0, mem_ce}, 64'd1);
    chk("inflight_beat1_addr", mem_addr, BASE + 64'h48);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst2_resp", {61'd0, resp_valid, resp_misalign, |resp_rdata}, 64'd0);
    chk("rst2_mem_ctl", {54'd0, mem_ce, mem_we, mem_wmask}, 64'd0);
    chk("rst2_mem_addr", mem_addr, 64'd0);
    chk("rst2_mem_wdata", mem_wdata, 64'd0);
    c0 = ce_cnt;
    rv_seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      rv_seen = rv_seen | resp_valid;
    end
    chk("rst2_no_ce", 64'(ce_cnt - c0), 64'd0);
    chk("rst2_no_resp", {63'd0, rv_seen}, 64'd0);
    chk("rst2_idle", {63'd0, req_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
